// File: rtl/mgmt_irq_controller.sv
// mgmt_irq_controller: synchronized sources, W1C status, mask, count, irq.
// Define MGMT_IRQ_COALESCE_EN to add the irq coalescing holdoff FSM.
module mgmt_irq_controller #(
    parameter int unsigned   NUM_SRC        = 8,
    parameter logic [7:0]    LEVEL_MASK     = 8'h00,
    parameter logic [15:0]   BASE_ADDR      = 16'h0040,
    parameter int unsigned   HOLDOFF_CYCLES = 1875
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_level,
    input  logic               rd_en,
    input  logic [15:0]        rd_addr,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    input  logic               wr_en,
    input  logic [15:0]        wr_addr,
    input  logic [7:0]         wr_data,
    output logic               irq
);

    localparam int unsigned W = NUM_SRC;

    logic [W-1:0] sync1_q;
    logic [W-1:0] raw_q;
    logic [W-1:0] raw_prev_q;
    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] set_evt;
    logic [W-1:0] w1c;
    logic [W-1:0] lvl;
    logic [7:0]   count_q, count_d;
    logic         irq_q, irq_d;
    logic         irq_req;
    logic         rd_valid_q, rd_valid_d;
    logic [7:0]   rd_data_q, rd_data_d;
    logic [15:0]  rd_off;
    logic [15:0]  wr_off;
    logic         rd_hit;
    logic         wr_hit;

    function automatic logic [7:0] ext8(input logic [W-1:0] v);
        ext8 = 8'(v);
    endfunction

    // Wrap-around subtraction folds both range bounds into one compare.
    assign rd_off = rd_addr - BASE_ADDR;
    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_hit = rd_en && (rd_off < 16'd4);
    assign wr_hit = wr_en && (wr_off < 16'd4);
    assign lvl    = LEVEL_MASK[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            raw_q      <= '0;
            raw_prev_q <= '0;
        end else begin
            sync1_q    <= src_level;
            raw_q      <= sync1_q;
            raw_prev_q <= raw_q;
        end
    end

    always_comb begin
        set_evt   = (raw_q & lvl) | (raw_q & ~raw_prev_q & ~lvl);
        w1c       = '0;
        mask_d    = mask_q;
        if (wr_hit && wr_off[1:0] == 2'd0) begin
            w1c = wr_data[W-1:0];
        end
        if (wr_hit && wr_off[1:0] == 2'd1) begin
            mask_d = wr_data[W-1:0];
        end
        pending_d = (pending_q & ~w1c) | set_evt;
        irq_req   = |(pending_q & mask_q);
    end

`ifdef MGMT_IRQ_COALESCE_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERTED,
        ST_HOLDOFF
    } state_t;

    localparam int unsigned HW =
        (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    state_t        state_q;
    logic [HW-1:0] hold_q;

    assign irq_d = irq_req && (state_q != ST_HOLDOFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (irq_req) begin
                        state_q <= ST_ASSERTED;
                    end
                end
                ST_ASSERTED: begin
                    if (!irq_req) begin
                        state_q <= ST_HOLDOFF;
                        hold_q  <= HOLD_LOAD;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign irq_d = irq_req;
`endif

    always_comb begin
        count_d = count_q;
        if (wr_hit && wr_off[1:0] == 2'd3) begin
            count_d = 8'h00;
        end else if (irq_d && !irq_q && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    // Read data is taken from pre-update state, so a W1C in the same
    // cycle does not hide the bits being cleared.
    always_comb begin
        rd_valid_d = rd_hit;
        rd_data_d  = 8'h00;
        if (rd_hit) begin
            unique case (rd_off[1:0])
                2'd0: rd_data_d = ext8(pending_q);
                2'd1: rd_data_d = ext8(mask_q);
                2'd2: rd_data_d = ext8(raw_q);
                2'd3: rd_data_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            mask_q     <= '0;
            count_q    <= 8'h00;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign irq      = irq_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
